vga_sprite_writer: RTL

VGA_SPRITE_WRITER -- requirements
Module: vga_sprite_writer

---
 rtl/vga_sprite_writer_if.sv | 23 ++
 rtl/vga_sprite_writer.sv | 83 ++++++++
 2 files changed

// File: rtl/vga_sprite_writer_if.sv
// Pixel-stream and sprite-RAM write bus for vga_sprite_writer.
// The producer/test side uses master; the writer itself uses slave.
interface vga_sprite_writer_if;
  logic        start;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_done;

  modport master (
    output start, pix_valid, pix_data,
    input  pix_ready, wr_en, wr_addr, wr_data, busy, frame_done
  );

  modport slave (
    input  start, pix_valid, pix_data,
    output pix_ready, wr_en, wr_addr, wr_data, busy, frame_done
  );
endinterface

// File: rtl/vga_sprite_writer.sv
// Streams one WIDTH x HEIGHT frame of RGB332 pixels into sprite RAM in raster order.
// The write address is a running counter kept in step with the x/y position.
module vga_sprite_writer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_sprite_writer_if.slave  bus
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  if (WIDTH * HEIGHT > 32768) begin : g_size_check
    $error("vga_sprite_writer: WIDTH*HEIGHT exceeds the 15-bit address space");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t      state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [14:0] addr;
  logic        last_x;
  logic        last_y;

  assign last_x = (x == XW'(WIDTH - 1));
  assign last_y = (y == YW'(HEIGHT - 1));

  // Status outputs are pure decodes of the state register, so reset clears them at once.
  assign bus.pix_ready  = (state == LOAD);
  assign bus.busy       = (state == LOAD);
  assign bus.frame_done = (state == DONE);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      // wr_en is a one-cycle strobe; address and data simply hold between writes.
      bus.wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= LOAD;
            x     <= '0;
            y     <= '0;
            addr  <= '0;
          end
        end
        LOAD: begin
          if (bus.pix_valid) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= addr;
            bus.wr_data <= bus.pix_data;
            addr        <= addr + 15'd1;
            if (last_x) begin
              x <= '0;
              if (last_y) state <= DONE;
              else        y     <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
